pong_object_engine: RTL

Parametrised per-frame game-object engine for the VGA pong display: owns both paddles and the ball, advances them once per video frame, resolves wall and paddle bounces, keeps score and runs a serve/play/game-over state machine. Sits between the player button inputs, the frame timing generator and the pixel colour mux. Every position and score is a register in the system clock domain. Registered per-pixel hit flags tell the colour mux which object covers the current (x, y).

---
 rtl/pong_object_engine.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pong_object_engine.sv
// Per-frame game-object engine for VGA pong: paddles, ball, bounces, score and
// serve/play/over sequencing, plus registered per-pixel object hit flags.
module pong_object_engine #(
  parameter int unsigned WIDTH        = 640,
  parameter int unsigned HEIGHT       = 480,
  parameter int unsigned PAD_HW       = 25,
  parameter int unsigned PAD_HH       = 33,
  parameter int unsigned BALL_R       = 4,
  parameter int unsigned PAD_SPEED    = 1,
  parameter int unsigned BALL_VX      = 2,
  parameter int unsigned BALL_VY      = 1,
  parameter int unsigned P1_XMIN      = 26,
  parameter int unsigned P1_XMAX      = 270,
  parameter int unsigned P2_XMIN      = 370,
  parameter int unsigned P2_XMAX      = 614,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frameTick,
  input  logic [3:0] p1_btn,
  input  logic [3:0] p2_btn,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       ball_hit,
  output logic [9:0] p1_x,
  output logic [9:0] p2_x,
  output logic [9:0] ball_x,
  output logic [8:0] p1_y,
  output logic [8:0] p2_y,
  output logic [8:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic [1:0] winner,
  output logic       p2_cross
);

  localparam int unsigned PW = 12;
  localparam int unsigned CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0] P1_X0   = 10'd80;
  localparam logic [9:0] P2_X0   = 10'(WIDTH - 80);
  localparam logic [8:0] PAD_Y0  = 9'(HEIGHT / 2);
  localparam logic [9:0] BALL_X0 = 10'(WIDTH / 2);
  localparam logic [8:0] BALL_Y0 = 9'(HEIGHT / 2);

  localparam logic [PW-1:0] SPD   = PW'(PAD_SPEED);
  localparam logic [PW-1:0] P1_LO = PW'(P1_XMIN);
  localparam logic [PW-1:0] P1_HI = PW'(P1_XMAX);
  localparam logic [PW-1:0] P2_LO = PW'(P2_XMIN);
  localparam logic [PW-1:0] P2_HI = PW'(P2_XMAX);
  localparam logic [PW-1:0] Y_LO  = PW'(PAD_HH + 1);
  localparam logic [PW-1:0] Y_HI  = PW'(HEIGHT - PAD_HH - 2);

  localparam logic signed [PW-1:0] S_ZERO = '0;
  localparam logic signed [PW-1:0] S_HW   = PW'(PAD_HW);
  localparam logic signed [PW-1:0] S_HH   = PW'(PAD_HH);
  localparam logic signed [PW-1:0] S_R    = PW'(BALL_R);
  localparam logic signed [PW-1:0] S_VX   = PW'(BALL_VX);
  localparam logic signed [PW-1:0] S_VY   = PW'(BALL_VY);
  localparam logic signed [PW-1:0] S_WMAX = PW'(WIDTH - 1);
  localparam logic signed [PW-1:0] S_HMAX = PW'(HEIGHT - 1);

  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, OVER = 2'd2} gameState_e;

  gameState_e curState, nxtState;
  logic          frameTickQ, tick;
  logic          ballVxNeg, ballVyNeg, serveNeg;
  logic          vxNegNxt, vyNegNxt, serveNegNxt;
  logic [CW-1:0] serveCnt, serveCntNxt;
  logic [9:0]    p1XNxt, p2XNxt, ballXNxt;
  logic [8:0]    p1YNxt, p2YNxt, ballYNxt;
  logic [3:0]    p1ScoreNxt, p2ScoreNxt;
  logic [1:0]    winnerNxt;
  logic signed [PW-1:0] nx, ny;
  logic          scoreP1, scoreP2;

  function automatic logic signed [PW-1:0] sx(input logic [PW-1:0] v);
    return $signed(v);
  endfunction

  // One step toward the pressed direction, saturating at the bound.
  function automatic logic [PW-1:0] movePaddle(input logic [PW-1:0] cur, input logic dec,
                                               input logic inc, input logic [PW-1:0] lo,
                                               input logic [PW-1:0] hi);
    logic [PW-1:0] res;
    res = cur;
    if (dec && !inc)      res = (cur < lo + SPD) ? lo : cur - SPD;
    else if (inc && !dec) res = (cur + SPD > hi) ? hi : cur + SPD;
    return res;
  endfunction

  function automatic logic boxOverlap(input logic signed [PW-1:0] bx, by, px, py);
    return (bx + S_R >= px - S_HW) && (bx - S_R <= px + S_HW) &&
           (by + S_R >= py - S_HH) && (by - S_R <= py + S_HH);
  endfunction

  function automatic logic covers(input logic signed [PW-1:0] qx, qy, cx, cy, hw, hh);
    return (qx > cx - hw) && (qx < cx + hw) && (qy > cy - hh) && (qy < cy + hh);
  endfunction

  assign state = curState;

  // Next-state and per-frame object update
  always_comb begin
    nxtState    = curState;
    p1XNxt      = p1_x;
    p1YNxt      = p1_y;
    p2XNxt      = p2_x;
    p2YNxt      = p2_y;
    ballXNxt    = ball_x;
    ballYNxt    = ball_y;
    vxNegNxt    = ballVxNeg;
    vyNegNxt    = ballVyNeg;
    serveNegNxt = serveNeg;
    serveCntNxt = serveCnt;
    p1ScoreNxt  = p1_score;
    p2ScoreNxt  = p2_score;
    winnerNxt   = winner;
    nx          = S_ZERO;
    ny          = S_ZERO;
    scoreP1     = 1'b0;
    scoreP2     = 1'b0;

    if (tick && curState != OVER) begin
      p1XNxt = 10'(movePaddle(PW'(p1_x), p1_btn[1], p1_btn[0], P1_LO, P1_HI));
      p1YNxt = 9'(movePaddle(PW'(p1_y), p1_btn[3], p1_btn[2], Y_LO, Y_HI));
      p2XNxt = 10'(movePaddle(PW'(p2_x), p2_btn[1], p2_btn[0], P2_LO, P2_HI));
      p2YNxt = 9'(movePaddle(PW'(p2_y), p2_btn[3], p2_btn[2], Y_LO, Y_HI));
    end

    if (tick) begin
      unique case (curState)
        SERVE: begin
          ballXNxt = BALL_X0;
          ballYNxt = BALL_Y0;
          if (serveCnt == '0) begin
            nxtState = PLAY;
            vxNegNxt = serveNeg;
            vyNegNxt = 1'b0;
          end else begin
            serveCntNxt = serveCnt - CW'(1);
          end
        end
        PLAY: begin
          nx = sx(PW'(ball_x)) + (ballVxNeg ? -S_VX : S_VX);
          ny = sx(PW'(ball_y)) + (ballVyNeg ? -S_VY : S_VY);
          if (ny - S_R < S_ZERO) begin
            ny       = S_R;
            vyNegNxt = 1'b0;
          end else if (ny + S_R > S_HMAX) begin
            ny       = S_HMAX - S_R;
            vyNegNxt = 1'b1;
          end
          // Paddle tests use the pre-tick paddle positions
          if (ballVxNeg && boxOverlap(nx, ny, sx(PW'(p1_x)), sx(PW'(p1_y)))) begin
            nx       = sx(PW'(p1_x)) + S_HW + S_R + PW'(1);
            vxNegNxt = 1'b0;
          end
          if (!ballVxNeg && boxOverlap(nx, ny, sx(PW'(p2_x)), sx(PW'(p2_y)))) begin
            nx       = sx(PW'(p2_x)) - S_HW - S_R - PW'(1);
            vxNegNxt = 1'b1;
          end
          if (nx - S_R <= S_ZERO)        scoreP2 = 1'b1;
          else if (nx + S_R >= S_WMAX)   scoreP1 = 1'b1;

          if (scoreP1 || scoreP2) begin
            ballXNxt    = BALL_X0;
            ballYNxt    = BALL_Y0;
            serveCntNxt = CW'(SERVE_FRAMES);
            nxtState    = SERVE;
            if (scoreP1) begin
              p1ScoreNxt  = p1_score + 4'd1;
              serveNegNxt = 1'b1;
              if (p1ScoreNxt == 4'(WIN_SCORE)) begin
                nxtState  = OVER;
                winnerNxt = 2'd1;
              end
            end else begin
              p2ScoreNxt  = p2_score + 4'd1;
              serveNegNxt = 1'b0;
              if (p2ScoreNxt == 4'(WIN_SCORE)) begin
                nxtState  = OVER;
                winnerNxt = 2'd2;
              end
            end
          end else begin
            ballXNxt = 10'(nx);
            ballYNxt = 9'(ny);
          end
        end
        default: ;
      endcase
    end
  end

  // State registers, frame-edge detect and per-pixel hit flags
  always_ff @(posedge clk) begin
    if (reset) begin
      curState   <= SERVE;
      frameTickQ <= 1'b0;
      tick       <= 1'b0;
      p1_x       <= P1_X0;
      p1_y       <= PAD_Y0;
      p2_x       <= P2_X0;
      p2_y       <= PAD_Y0;
      ball_x     <= BALL_X0;
      ball_y     <= BALL_Y0;
      ballVxNeg  <= 1'b0;
      ballVyNeg  <= 1'b0;
      serveNeg   <= 1'b0;
      serveCnt   <= CW'(SERVE_FRAMES);
      p1_score   <= '0;
      p2_score   <= '0;
      winner     <= '0;
      p2_cross   <= (P2_X0 >= 10'(P2_XMIN));
      p1_hit     <= 1'b0;
      p2_hit     <= 1'b0;
      ball_hit   <= 1'b0;
    end else begin
      curState   <= nxtState;
      frameTickQ <= frameTick;
      tick       <= frameTick & ~frameTickQ;
      p1_x       <= p1XNxt;
      p1_y       <= p1YNxt;
      p2_x       <= p2XNxt;
      p2_y       <= p2YNxt;
      ball_x     <= ballXNxt;
      ball_y     <= ballYNxt;
      ballVxNeg  <= vxNegNxt;
      ballVyNeg  <= vyNegNxt;
      serveNeg   <= serveNegNxt;
      serveCnt   <= serveCntNxt;
      p1_score   <= p1ScoreNxt;
      p2_score   <= p2ScoreNxt;
      winner     <= winnerNxt;
      p2_cross   <= (p2XNxt >= 10'(P2_XMIN));
      p1_hit     <= covers(sx(PW'(x)), sx(PW'(y)), sx(PW'(p1_x)), sx(PW'(p1_y)), S_HW, S_HH);
      p2_hit     <= covers(sx(PW'(x)), sx(PW'(y)), sx(PW'(p2_x)), sx(PW'(p2_y)), S_HW, S_HH);
      ball_hit   <= covers(sx(PW'(x)), sx(PW'(y)), sx(PW'(ball_x)), sx(PW'(ball_y)), S_R, S_R);
    end
  end

endmodule
